// File: rtl/max_pooling_ctrl.sv
// Row-pair sequencer for a 2x2 stride-2 max-pooling datapath: reads rows 2r and
// 2r+1, holds them on pool_in, and hands the pooled row downstream via valid/ready.
module max_pooling_ctrl #(
  parameter int DATA_BITS = 32,
  parameter int D         = 32,
  parameter int W         = 92,
  parameter int H         = 92,
  parameter int ROW_AW    = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              rd_en,
  output logic [ROW_AW-1:0]                 rd_addr,
  input  logic [W*D*DATA_BITS-1:0]          rd_data,
  output logic [2*W*D*DATA_BITS-1:0]        pool_in,
  input  logic [(W/2)*D*DATA_BITS-1:0]      pool_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ROW_AW-1:0]                 out_row,
  output logic [(W/2)*D*DATA_BITS-1:0]      out_data
);

  localparam int ROW_BITS = W * D * DATA_BITS;
  localparam int OUT_BITS = (W / 2) * D * DATA_BITS;
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(H / 2 - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_TOP = 3'd1;
  localparam logic [2:0] S_RD_BOT = 3'd2;
  localparam logic [2:0] S_LATCH  = 3'd3;
  localparam logic [2:0] S_POOL   = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  logic [2:0]          r_state;
  logic [ROW_AW-1:0]   r_rowIdx;
  logic                r_rdEn;
  logic [ROW_AW-1:0]   r_rdAddr;
  logic [ROW_BITS-1:0] r_topRow;
  logic [ROW_BITS-1:0] r_botRow;
  logic                r_outValid;
  logic [ROW_AW-1:0]   r_outRow;
  logic [OUT_BITS-1:0] r_outData;
  logic                r_done;
  logic [ROW_AW-1:0]   w_nextRow;

  assign w_nextRow = r_rowIdx + 1'b1;

  // Read strobe and address are registered one state ahead, so they are
  // glitch-free and rd_addr naturally holds its last value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rowIdx   <= '0;
      r_rdEn     <= 1'b0;
      r_rdAddr   <= '0;
      r_topRow   <= '0;
      r_botRow   <= '0;
      r_outValid <= 1'b0;
      r_outRow   <= '0;
      r_outData  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_RD_TOP;
            r_rowIdx <= '0;
            r_rdEn   <= 1'b1;
            r_rdAddr <= '0;
          end
        end
        S_RD_TOP: begin
          r_state  <= S_RD_BOT;
          r_rdAddr <= {r_rowIdx[ROW_AW-2:0], 1'b1};
        end
        S_RD_BOT: begin
          r_state  <= S_LATCH;
          r_topRow <= rd_data;
          r_rdEn   <= 1'b0;
        end
        S_LATCH: begin
          r_state  <= S_POOL;
          r_botRow <= rd_data;
        end
        S_POOL: begin
          r_state    <= S_OUT;
          r_outData  <= pool_out;
          r_outRow   <= r_rowIdx;
          r_outValid <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            if (r_rowIdx == LAST_ROW) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_RD_TOP;
              r_rowIdx <= w_nextRow;
              r_rdEn   <= 1'b1;
              r_rdAddr <= {w_nextRow[ROW_AW-2:0], 1'b0};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign rd_en     = r_rdEn;
  assign rd_addr   = r_rdAddr;
  assign pool_in   = {r_botRow, r_topRow};
  assign out_valid = r_outValid;
  assign out_row   = r_outRow;
  assign out_data  = r_outData;

endmodule
